ysyx_22040632_regfile_sb: RTL
=============================

# ysyx_22040632_regfile_sb

Parametrised general-purpose register file with an integrated write-back scoreboard. It sits in the decode stage and replaces the fixed 32×64, single-write-port array and its ad-hoc load-use blocking. It provides NRD combinational read ports and NWR write-back ports. Per-register in-flight counters tell decode whether an operand is still pending, and decode is stalled until it is not.

## Interface
- XLEN, 64, register data width
- NREG, 32, number of architectural registers (power of two; register 0 hardwired to zero)
- NRD, 2, number of read ports
- NWR, 2, number of write-back/release ports
- CW, 2, scoreboard counter width (max 2^CW−1 writes in flight per register)
- clk  in  1  clock
- rrst_n  in  1  asynchronous active-low reset
- rd_addr  in  NRD×log2(NREG)  read-port register indices
- rd_data  out  NRD×XLEN  read data (combinational)
- rd_busy  out  NRD  register has an outstanding write
- iss_vld  in  1  decode presents an instruction this cycle
- iss_rs_used  in  NRD  which read ports the instruction actually needs
- iss_rd_en  in  1  instruction writes a destination
- iss_rd  in  log2(NREG)  destination index
- iss_stall  out  1  instruction must be held in decode
- wb_vld  in  NWR  port retires one op (releases one scoreboard count)
- wb_wen  in  NWR  port writes data (only meaningful with wb_vld)
- wb_addr  in  NWR×log2(NREG)  destination index per port
- wb_data  in  NWR×XLEN  write data per port
- regs_o  out  NREG×XLEN  architectural view for difftest
- sb_err  out  1  sticky: release on a zero counter

## Operation
- Issue fires when iss_vld & !iss_stall. On fire with iss_rd_en & iss_rd≠0, cnt[iss_rd] is incremented.
- iss_stall = iss_vld & (any port p with iss_rs_used[p] & rd_busy[p], or iss_rd_en & iss_rd≠0 & cnt[iss_rd] at maximum).
- Each wb_vld[p] with wb_addr[p]≠0 decrements cnt[wb_addr[p]] by one.
- If wb_wen[p] is also set, gpr[wb_addr[p]] ← wb_data[p].
- Flushed ops must still be released, using wb_vld=1 with wb_wen=0.
- Register 0: never written, counter held at 0, always reads 0, never busy.
- Several ports writing the same register in one cycle: the highest port index wins the data. All of those ports release, so the counter is decremented by the number of ports.
- Alloc and release of the same register in one cycle: net counter change is +1 −k.
- A release on a counter that is already 0 leaves the counter at 0 and sets sb_err. sb_err is cleared only by reset.
- regs_o is the post-write-back view: gpr merged with this cycle's wb_wen writes (same priority rule).

## Timing
- Reset (async, rrst_n low): all gpr = 0, all cnt = 0, sb_err = 0.
  - Outputs during reset: rd_data = 0, rd_busy = 0, iss_stall = 0.
  - Reset mid-operation discards all in-flight counts.
- Writes and counter updates take effect at the rising clk edge. The array read-after-write latency is 1 cycle.
- rd_data, rd_busy and iss_stall are combinational from the current inputs and state. There are no registered outputs.
- rd_busy[p] = cnt[rd_addr[p]]≠0 (modified by the bypass macro, see Configuration).

## Configuration
- YSYX_22040632_REGFILE_BYPASS_EN defined:
  - rd_data[p] returns the matching same-cycle wb_wen data (highest port wins).
  - rd_busy[p] is evaluated on the counter after this cycle's releases, so an operand whose last write-back is arriving this cycle issues with zero bubble.
- YSYX_22040632_REGFILE_BYPASS_EN undefined:
  - rd_data comes from the array only, and rd_busy uses the pre-release counter. Dependent issue therefore occurs one cycle after the write-back.
  - regs_o still shows merged data.

## Structure
- Shared package holds:
  - the register-index typedef (log2(NREG) bits);
  - the write-back port struct {vld, wen, addr, data};
  - the default parameter constants.
- Sub-module ysyx_22040632_sb_cnt holds one saturating up/down counter.
  - Inputs: inc, dec count (0..NWR).
  - Outputs: busy, full, underflow.
  - Instantiated NREG−1 times via generate.
- The top level holds the data array, write-priority muxes, read/bypass muxes and the stall logic.

## Test plan
- Reset release, read x0..x31 → all 0, rd_busy=0, sb_err=0. Write x0=0xDEAD via wb → x0 still reads 0.
- Issue rd=x5, then two cycles later wb_vld/wen x5=0x1234. Issue a consumer with rs=x5 on the write-back cycle:
  - with bypass: no stall, rd_data=0x1234;
  - without bypass: stall 1 cycle, then 0x1234.
- CW=2: issue 3 writers of x7 back to back, then a 4th → iss_stall=1 until one wb_vld on x7. Counter returns to 0 after 3 releases.
- Same cycle: wb port0 writes x9=0xA, port1 writes x9=0xB, with cnt[x9]=2 → x9=0xB, cnt=0.
- Flushed op: alloc x3, release with wb_vld=1, wb_wen=0 → x3 data unchanged, rd_busy clears. A further release on x3 → sb_err=1, held until reset.
- Assert rrst_n low with cnt[x4]=2 and a pending consumer → all counters 0 and iss_stall=0 immediately (asynchronously).

Source files
------------

// File: rtl/ysyx_22040632_regfile_sb_pkg.sv
// Shared types and default sizing for the register file / write-back scoreboard.
// Optional same-cycle bypass is selected by YSYX_22040632_REGFILE_BYPASS_EN.
package ysyx_22040632_regfile_sb_pkg;

  localparam int DEF_XLEN = 64;
  localparam int DEF_NREG = 32;
  localparam int DEF_NRD  = 2;
  localparam int DEF_NWR  = 2;
  localparam int DEF_CW   = 2;

  typedef logic [$clog2(DEF_NREG)-1:0] reg_idx_t;

  typedef struct packed {
    logic                vld;
    logic                wen;
    reg_idx_t            addr;
    logic [DEF_XLEN-1:0] data;
  } wb_port_t;

  // Width needed to count 0..nwr simultaneous releases.
  function automatic int dec_width(input int nwr);
    return $clog2(nwr + 1);
  endfunction

endpackage

// File: rtl/ysyx_22040632_regfile_sb_cnt.sv
// One per-register in-flight counter: +inc, -dec per cycle, clamped at 0 and max.
// POST_REL selects whether busy reflects the counter after this cycle's releases.
module ysyx_22040632_sb_cnt #(
  parameter int CW       = 2,
  parameter int DW       = 2,
  parameter bit POST_REL = 1'b0
) (
  input  logic          clk,
  input  logic          rrst_n,
  input  logic          inc,
  input  logic [DW-1:0] dec,
  output logic          busy,
  output logic          full,
  output logic          underflow
);

  localparam int SW = ((CW > DW) ? CW : DW) + 1;
  localparam logic [CW-1:0] MAX = {CW{1'b1}};

  logic [CW-1:0] cnt_r;
  logic [SW-1:0] up_s;
  logic [SW-1:0] nxt_s;

  // Next count; a release beyond zero clamps to zero and flags underflow.
  always_comb begin
    up_s      = SW'(cnt_r) + SW'(inc);
    underflow = (SW'(dec) > up_s);
    if (underflow) begin
      nxt_s = '0;
    end else if ((up_s - SW'(dec)) > SW'(MAX)) begin
      nxt_s = SW'(MAX);
    end else begin
      nxt_s = up_s - SW'(dec);
    end
  end

  assign full = (cnt_r == MAX);
  assign busy = POST_REL ? (SW'(cnt_r) > SW'(dec)) : (cnt_r != '0);

  // Counter state register.
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= nxt_s[CW-1:0];
    end
  end

endmodule

// File: rtl/ysyx_22040632_regfile_sb.sv
// Register file with per-register write-back scoreboard and decode stall.
// Define YSYX_22040632_REGFILE_BYPASS_EN to forward same-cycle write-backs to the read ports.
module ysyx_22040632_regfile_sb
  import ysyx_22040632_regfile_sb_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG,
  parameter int NRD  = DEF_NRD,
  parameter int NWR  = DEF_NWR,
  parameter int CW   = DEF_CW
) (
  input  logic                          clk,
  input  logic                          rrst_n,
  input  logic [NRD*$clog2(NREG)-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0]           rd_data,
  output logic [NRD-1:0]                rd_busy,
  input  logic                          iss_vld,
  input  logic [NRD-1:0]                iss_rs_used,
  input  logic                          iss_rd_en,
  input  logic [$clog2(NREG)-1:0]       iss_rd,
  output logic                          iss_stall,
  input  logic [NWR-1:0]                wb_vld,
  input  logic [NWR-1:0]                wb_wen,
  input  logic [NWR*$clog2(NREG)-1:0]   wb_addr,
  input  logic [NWR*XLEN-1:0]           wb_data,
  output logic [NREG*XLEN-1:0]          regs_o,
  output logic                          sb_err
);

  localparam int AW = $clog2(NREG);
  localparam int DW = dec_width(NWR);
`ifdef YSYX_22040632_REGFILE_BYPASS_EN
  localparam bit POST_REL = 1'b1;
`else
  localparam bit POST_REL = 1'b0;
`endif

  logic [XLEN-1:0] gpr_r    [NREG];
  logic [XLEN-1:0] merged_s [NREG];
  logic            wr_en_s  [NREG];
  logic [DW-1:0]   dec_s    [NREG];
  logic [NREG-1:0] busy_s;
  logic [NREG-1:0] full_s;
  logic [NREG-1:0] unf_s;
  logic [NREG-1:0] inc_s;
  logic            fire_s;
  logic            sb_err_r;

  // Write-back merge: ascending port loop so the highest port wins; count releases.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      wr_en_s[i]  = 1'b0;
      merged_s[i] = gpr_r[i];
      dec_s[i]    = '0;
    end
    for (int p = 0; p < NWR; p++) begin
      if (wb_vld[p] && (wb_addr[p*AW +: AW] != '0)) begin
        dec_s[wb_addr[p*AW +: AW]] = dec_s[wb_addr[p*AW +: AW]] + DW'(1);
        if (wb_wen[p]) begin
          wr_en_s[wb_addr[p*AW +: AW]]  = 1'b1;
          merged_s[wb_addr[p*AW +: AW]] = wb_data[p*XLEN +: XLEN];
        end else begin
          wr_en_s[wb_addr[p*AW +: AW]]  = wr_en_s[wb_addr[p*AW +: AW]];
        end
      end else begin
        wr_en_s[0] = 1'b0;
      end
    end
  end

  // Data array; entry 0 is only ever reset, so it always reads zero.
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < NREG; i++) gpr_r[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (wr_en_s[i]) gpr_r[i] <= merged_s[i];
      end
    end
  end

  assign busy_s[0] = 1'b0;
  assign full_s[0] = 1'b0;
  assign unf_s[0]  = 1'b0;
  assign inc_s[0]  = 1'b0;

  genvar g;
  generate
    for (g = 1; g < NREG; g++) begin : g_cnt
      assign inc_s[g] = fire_s & iss_rd_en & (iss_rd == AW'(g));
      ysyx_22040632_sb_cnt #(.CW(CW), .DW(DW), .POST_REL(POST_REL)) u_cnt (
        .clk       (clk),
        .rrst_n    (rrst_n),
        .inc       (inc_s[g]),
        .dec       (dec_s[g]),
        .busy      (busy_s[g]),
        .full      (full_s[g]),
        .underflow (unf_s[g])
      );
    end
  endgenerate

  // Read ports, stall decision and difftest view; forwarded data is masked during reset.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    regs_o  = '0;
    for (int q = 0; q < NRD; q++) begin
`ifdef YSYX_22040632_REGFILE_BYPASS_EN
      rd_data[q*XLEN +: XLEN] = rrst_n ? merged_s[rd_addr[q*AW +: AW]] : '0;
`else
      rd_data[q*XLEN +: XLEN] = gpr_r[rd_addr[q*AW +: AW]];
`endif
      rd_busy[q] = busy_s[rd_addr[q*AW +: AW]];
    end
    for (int i = 0; i < NREG; i++) begin
      regs_o[i*XLEN +: XLEN] = rrst_n ? merged_s[i] : '0;
    end
    iss_stall = iss_vld & ((|(iss_rs_used & rd_busy)) |
                           (iss_rd_en & (iss_rd != '0) & full_s[iss_rd]));
    fire_s    = iss_vld & ~iss_stall;
  end

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      sb_err_r <= 1'b0;
    end else if (|unf_s) begin
      sb_err_r <= 1'b1;
    end else begin
      sb_err_r <= sb_err_r;
    end
  end

  assign sb_err = sb_err_r;

endmodule
